// File: rtl/bcd_timer_n.sv
// Parametrised BCD up/down timer: NFIELDS two-digit BCD fields, least-significant first,
// with run/pause, per-field adjust with press-and-hold auto-repeat, and a terminal done pulse.
module bcd_timer_n #(
  parameter int NFIELDS = 2,
  parameter int TOP_MOD = 60,
  parameter bit WRAP    = 1'b0,
  parameter int SELW    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   rpt_tick,
  input  logic                   run_toggle,
  input  logic                   dir,
  input  logic                   adj,
  input  logic [SELW-1:0]        adj_sel,
  input  logic                   inc,
  input  logic                   dec,
  output logic [8*NFIELDS-1:0]   digits,
  output logic                   running,
  output logic                   at_zero,
  output logic                   at_max,
  output logic                   done
);
  localparam int W = 8 * NFIELDS;

  function automatic int field_mod(input int k);
    return (k == NFIELDS - 1) ? TOP_MOD : 60;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return 10 * int'(b[7:4]) + int'(b[3:0]);
  endfunction

  // One field stepped by +/-1, wrapping modulo that field's own modulus.
  function automatic logic [7:0] field_next(input logic [7:0] b, input int k, input logic down);
    int v;
    int m;
    v = from_bcd(b);
    m = field_mod(k);
    if (down) v = (v == 0) ? m - 1 : v - 1;
    else      v = (v == m - 1) ? 0 : v + 1;
    return to_bcd(v);
  endfunction

  function automatic logic [W-1:0] max_digits();
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < NFIELDS; k++) r[8*k +: 8] = to_bcd(field_mod(k) - 1);
    return r;
  endfunction

  // Whole-count step: carry (or borrow) ripples into the next field only on a field wrap.
  function automatic logic [W-1:0] count_step(input logic [W-1:0] d, input logic down);
    logic [W-1:0] r;
    logic         carry;
    r     = d;
    carry = 1'b1;
    for (int k = 0; k < NFIELDS; k++) begin
      if (carry) begin
        r[8*k +: 8] = field_next(d[8*k +: 8], k, down);
        carry = down ? (d[8*k +: 8] == 8'h00) : (d[8*k +: 8] == to_bcd(field_mod(k) - 1));
      end
    end
    return r;
  endfunction

  // Adjust touches only the selected field; an out-of-range selector matches nothing.
  function automatic logic [W-1:0] adjust_step(input logic [W-1:0] d, input logic [SELW-1:0] sel,
                                               input logic down);
    logic [W-1:0] r;
    r = d;
    for (int k = 0; k < NFIELDS; k++) begin
      if (int'(sel) == k) r[8*k +: 8] = field_next(d[8*k +: 8], k, down);
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_VAL = max_digits();

  logic         inc_q;
  logic         dec_q;
  logic         step_up;
  logic         step_dn;
  logic [W-1:0] up_val;
  logic [W-1:0] dn_val;

  // A rising edge and a coincident rpt_tick collapse into a single step.
  assign step_up = inc & ~dec & (~inc_q | rpt_tick);
  assign step_dn = dec & ~inc & (~dec_q | rpt_tick);
  assign up_val  = count_step(digits, 1'b0);
  assign dn_val  = count_step(digits, 1'b1);
  assign at_zero = (digits == '0);
  assign at_max  = (digits == MAX_VAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      digits  <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      inc_q <= inc;
      dec_q <= dec;
      done  <= 1'b0;
      if (adj) begin
        if (step_up || step_dn) digits <= adjust_step(digits, adj_sel, step_dn);
      end else begin
        if (run_toggle) running <= ~running;
        // The tick uses the pre-toggle run state; a terminal stop overrides the toggle.
        if (running && tick) begin
          if (!dir) begin
            if (!at_max) begin
              digits <= up_val;
              if (up_val == MAX_VAL) begin
                done <= 1'b1;
                if (!WRAP) running <= 1'b0;
              end
            end else if (WRAP) begin
              digits <= '0;
            end
          end else begin
            if (!at_zero) begin
              digits <= dn_val;
              if (dn_val == '0) begin
                done <= 1'b1;
                if (!WRAP) running <= 1'b0;
              end
            end else if (WRAP) begin
              digits <= MAX_VAL;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_timer_n.sv
// Bench for bcd_timer_n: three configurations share one stimulus stream and are checked
// every cycle against an integer-count reference model.
module tb_bcd_timer_n;
  logic clk = 1'b0;
  logic rst, tick, rpt_tick, run_toggle, dir, adj, inc, dec;
  logic [1:0] adj_sel;

  logic [15:0] d0, d1;
  logic [23:0] d2;
  logic [2:0]  run_o, az_o, am_o, done_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int NF [3] = '{2, 2, 3};
  localparam int TM [3] = '{60, 60, 24};
  localparam int WR [3] = '{0, 1, 1};

  int m_cnt  [3];
  bit m_run  [3];
  bit m_done [3];
  bit m_incq, m_decq;

  always #5 clk = ~clk;

  bcd_timer_n #(.NFIELDS(2), .TOP_MOD(60), .WRAP(1'b0), .SELW(2)) u0 (
    .clk(clk), .rst(rst), .tick(tick), .rpt_tick(rpt_tick), .run_toggle(run_toggle),
    .dir(dir), .adj(adj), .adj_sel(adj_sel), .inc(inc), .dec(dec),
    .digits(d0), .running(run_o[0]), .at_zero(az_o[0]), .at_max(am_o[0]), .done(done_o[0]));

  bcd_timer_n #(.NFIELDS(2), .TOP_MOD(60), .WRAP(1'b1), .SELW(2)) u1 (
    .clk(clk), .rst(rst), .tick(tick), .rpt_tick(rpt_tick), .run_toggle(run_toggle),
    .dir(dir), .adj(adj), .adj_sel(adj_sel), .inc(inc), .dec(dec),
    .digits(d1), .running(run_o[1]), .at_zero(az_o[1]), .at_max(am_o[1]), .done(done_o[1]));

  bcd_timer_n #(.NFIELDS(3), .TOP_MOD(24), .WRAP(1'b1), .SELW(2)) u2 (
    .clk(clk), .rst(rst), .tick(tick), .rpt_tick(rpt_tick), .run_toggle(run_toggle),
    .dir(dir), .adj(adj), .adj_sel(adj_sel), .inc(inc), .dec(dec),
    .digits(d2), .running(run_o[2]), .at_zero(az_o[2]), .at_max(am_o[2]), .done(done_o[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int pow60(input int k);
    int r = 1;
    for (int j = 0; j < k; j++) r = r * 60;
    return r;
  endfunction

  function automatic int fmod(input int i, input int k);
    return (k == NF[i] - 1) ? TM[i] : 60;
  endfunction

  function automatic int total(input int i);
    return pow60(NF[i] - 1) * TM[i];
  endfunction

  function automatic logic [31:0] exp_digits(input int i);
    logic [31:0] r = '0;
    for (int k = 0; k < NF[i]; k++) begin
      int f = (m_cnt[i] / pow60(k)) % fmod(i, k);
      r[8*k +: 8] = 8'((f / 10) * 16 + (f % 10));
    end
    return r;
  endfunction

  function automatic logic [31:0] got_digits(input int i);
    case (i)
      0:       return {16'h0, d0};
      1:       return {16'h0, d1};
      default: return {8'h0, d2};
    endcase
  endfunction

  // Reference: the count is a plain integer in 0..total-1; fields are its mixed-radix digits.
  task automatic model_step();
    bit up_s, dn_s;
    up_s = inc && !dec && (!m_incq || rpt_tick);
    dn_s = dec && !inc && (!m_decq || rpt_tick);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_cnt[i] = 0; m_run[i] = 0; m_done[i] = 0;
      end else begin
        m_done[i] = 0;
        if (adj) begin
          if ((up_s || dn_s) && int'(adj_sel) < NF[i]) begin
            int w = pow60(int'(adj_sel));
            int m = fmod(i, int'(adj_sel));
            int f = (m_cnt[i] / w) % m;
            int g = up_s ? (f + 1) % m : (f + m - 1) % m;
            m_cnt[i] = m_cnt[i] + (g - f) * w;
          end
        end else begin
          bit r = m_run[i];
          int mx = total(i) - 1;
          if (run_toggle) m_run[i] = !m_run[i];
          if (r && tick) begin
            if (!dir) begin
              if (m_cnt[i] == mx) begin
                if (WR[i] != 0) m_cnt[i] = 0;
              end else begin
                m_cnt[i]++;
                if (m_cnt[i] == mx) begin
                  m_done[i] = 1;
                  if (WR[i] == 0) m_run[i] = 0;
                end
              end
            end else begin
              if (m_cnt[i] == 0) begin
                if (WR[i] != 0) m_cnt[i] = mx;
              end else begin
                m_cnt[i]--;
                if (m_cnt[i] == 0) begin
                  m_done[i] = 1;
                  if (WR[i] == 0) m_run[i] = 0;
                end
              end
            end
          end
        end
      end
    end
    m_incq = rst ? 1'b0 : inc;
    m_decq = rst ? 1'b0 : dec;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d.digits", i), got_digits(i), exp_digits(i));
      check($sformatf("u%0d.running", i), 32'(run_o[i]), 32'(m_run[i]));
      check($sformatf("u%0d.done", i), 32'(done_o[i]), 32'(m_done[i]));
      check($sformatf("u%0d.at_zero", i), 32'(az_o[i]), 32'(m_cnt[i] == 0));
      check($sformatf("u%0d.at_max", i), 32'(am_o[i]), 32'(m_cnt[i] == total(i) - 1));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic clear_pulses();
    rst = 0; tick = 0; rpt_tick = 0; run_toggle = 0;
  endtask

  task automatic do_reset();
    clear_pulses();
    rst = 1; adj = 0; inc = 0; dec = 0; dir = 0; adj_sel = 0;
    step();
    rst = 0;
  endtask

  task automatic press(input bit up, input int sel);
    adj = 1; adj_sel = 2'(sel);
    inc = up; dec = !up;
    step();
    inc = 0; dec = 0;
    step();
  endtask

  task automatic toggle_run();
    clear_pulses(); run_toggle = 1; step(); run_toggle = 0;
  endtask

  task automatic do_tick();
    clear_pulses(); tick = 1; step(); tick = 0;
  endtask

  int saw_done;

  initial begin
    clear_pulses();
    adj = 0; inc = 0; dec = 0; dir = 0; adj_sel = 0;
    do_reset();
    do_reset();
    check("rst.digits0", {16'h0, d0}, 32'h0);
    check("rst.running0", 32'(run_o[0]), 32'h0);

    // Plain count-up from zero.
    toggle_run();
    saw_done = 0;
    for (int t = 0; t < 61; t++) begin
      do_tick();
      if (done_o[0]) saw_done++;
    end
    check("up61.digits", {16'h0, d0}, 32'h0101);
    check("up61.running", 32'(run_o[0]), 32'h1);
    check("up61.no_done", saw_done, 0);

    // Preset 59:58, count up into max with WRAP=0.
    do_reset();
    press(0, 1); press(0, 0); press(0, 0);
    adj = 0; dir = 0;
    check("preset.digits", {16'h0, d0}, 32'h5958);
    toggle_run();
    do_tick();
    check("term.digits", {16'h0, d0}, 32'h5959);
    check("term.done", 32'(done_o[0]), 32'h1);
    check("term.running", 32'(run_o[0]), 32'h0);
    step();
    check("term.done_once", 32'(done_o[0]), 32'h0);
    toggle_run();
    saw_done = 0;
    for (int t = 0; t < 3; t++) begin
      do_tick();
      if (done_o[0]) saw_done++;
    end
    check("hold.digits", {16'h0, d0}, 32'h5959);
    check("hold.no_done", saw_done, 0);

    // Count down through zero with WRAP=1.
    do_reset();
    press(1, 0); press(1, 0);
    adj = 0; dir = 1;
    toggle_run();
    do_tick();
    check("dn.1", {16'h0, d1}, 32'h0001);
    do_tick();
    check("dn.0", {16'h0, d1}, 32'h0000);
    check("dn.done", 32'(done_o[1]), 32'h1);
    do_tick();
    check("dn.wrap", {16'h0, d1}, 32'h5959);
    check("dn.running", 32'(run_o[1]), 32'h1);
    dir = 0;

    // Press-and-hold auto-repeat on minutes.
    do_reset();
    press(0, 1); press(0, 1);
    adj = 1; adj_sel = 1; inc = 1;
    step();
    check("rpt.edge", {16'h0, d0}, 32'h5900);
    for (int r = 0; r < 5; r++) begin
      rpt_tick = 1; step();
      rpt_tick = 0; step();
    end
    check("rpt.digits", {16'h0, d0}, 32'h0400);
    check("rpt.running", 32'(run_o[0]), 32'h0);
    inc = 0; step();

    // Three fields, TOP_MOD=24: reach 23:59:59 then wrap.
    do_reset();
    press(0, 2); press(0, 1); press(0, 0); press(0, 0);
    adj = 0; dir = 0;
    toggle_run();
    do_tick();
    check("hms.max", {8'h0, d2}, 32'h235959);
    check("hms.done", 32'(done_o[2]), 32'h1);
    do_tick();
    check("hms.wrap", {8'h0, d2}, 32'h0);
    check("hms.wrap_done", 32'(done_o[2]), 32'h0);

    // Toggle coincident with tick while running.
    clear_pulses(); run_toggle = 1; tick = 1; step(); clear_pulses();
    check("tgl.digits", {8'h0, d2}, 32'h000001);
    check("tgl.running", 32'(run_o[2]), 32'h0);

    // inc and dec together, then reset during an adjust hold.
    do_reset();
    adj = 1; adj_sel = 0; inc = 1; dec = 1; rpt_tick = 1;
    step(); step();
    check("incdec.digits", {16'h0, d0}, 32'h0);
    dec = 0; rpt_tick = 0;
    step(); step();
    rst = 1; step(); rst = 0;
    check("rsthold.digits", {8'h0, d2}, 32'h0);
    check("rsthold.running", 32'(run_o[2]), 32'h0);
    inc = 0; adj = 0;

    // Randomised traffic.
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 499) == 0);
      tick       = ($urandom_range(0, 2) == 0);
      rpt_tick   = ($urandom_range(0, 4) == 0);
      run_toggle = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      if ($urandom_range(0, 59) == 0) begin
        adj = ~adj;
        adj_sel = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) inc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) dec = 1'($urandom_range(0, 1));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
